// File: rtl/tlb_n_entry_pkg.sv
// Shared types and helpers for the N-entry TLB.
// The per-entry record holds the valid and global flags.
package tlb_n_entry_pkg;

  localparam int unsigned ENTRIES_DEF = 8;
  localparam int unsigned VPN_W_DEF   = 20;
  localparam int unsigned PTE_W_DEF   = 24;
  localparam int unsigned ASID_W_DEF  = 8;

  // Tag, ASID and PTE payloads live in separately sized arrays in the top.
  typedef struct packed {
    logic valid;
    logic glb;
  } tlb_entry_flags_t;

  function automatic int unsigned tlb_clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tlb_n_entry_if.sv
// Command, lookup and probe bus of the N-entry TLB.
interface tlb_n_entry_if
  import tlb_n_entry_pkg::*;
#(
  parameter int unsigned ENTRIES = ENTRIES_DEF,
  parameter int unsigned VPN_W   = VPN_W_DEF,
  parameter int unsigned PTE_W   = PTE_W_DEF,
  parameter int unsigned ASID_W  = ASID_W_DEF
);
  localparam int unsigned IW = tlb_clog2(ENTRIES);

  logic              tlbwi;
  logic              tlbwr;
  logic              tlbp;
  logic              tlbinv;
  logic [IW-1:0]     index;
  logic [VPN_W-1:0]  vpn;
  logic [ASID_W-1:0] asid;
  logic [PTE_W-1:0]  pte_in;
  logic [PTE_W-1:0]  pte_out;
  logic              tlb_hit;
  logic              multi_hit;
  logic [IW-1:0]     probe_index;
  logic              probe_miss;
  logic [IW-1:0]     random;

  modport master (
    output tlbwi, tlbwr, tlbp, tlbinv, index, vpn, asid, pte_in,
    input  pte_out, tlb_hit, multi_hit, probe_index, probe_miss, random
  );

  modport slave (
    input  tlbwi, tlbwr, tlbp, tlbinv, index, vpn, asid, pte_in,
    output pte_out, tlb_hit, multi_hit, probe_index, probe_miss, random
  );

endinterface

// File: rtl/tlb_match_enc.sv
// Reduces a per-entry match vector to lowest matching index, any and multiple.
module tlb_match_enc
  import tlb_n_entry_pkg::*;
#(
  parameter int unsigned N = ENTRIES_DEF
) (
  input  logic [N-1:0]                match_i,
  output logic [tlb_clog2(N)-1:0]     lowest_idx_o,
  output logic                        any_o,
  output logic                        multi_o
);
  localparam int unsigned IW = tlb_clog2(N);

  // Ascending scan; the first hit latches so lower indices take priority.
  always_comb begin
    lowest_idx_o = '0;
    any_o        = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (match_i[i] && !any_o) begin
        lowest_idx_o = IW'(i);
        any_o        = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(match_i & (match_i - N'(1)));

endmodule

// File: rtl/tlb_n_entry.sv
// Fully associative N-entry TLB with indexed/random write, probe and flush.
module tlb_n_entry
  import tlb_n_entry_pkg::*;
#(
  parameter int unsigned ENTRIES = ENTRIES_DEF,
  parameter int unsigned VPN_W   = VPN_W_DEF,
  parameter int unsigned PTE_W   = PTE_W_DEF,
  parameter int unsigned ASID_W  = ASID_W_DEF
) (
  input logic         clk,
  input logic         clrn,
  tlb_n_entry_if.slave bus
);
  localparam int unsigned IW = tlb_clog2(ENTRIES);

  tlb_entry_flags_t  flags_q [ENTRIES];
  logic [VPN_W-1:0]  tag_q   [ENTRIES];
  logic [ASID_W-1:0] asid_q  [ENTRIES];
  logic [PTE_W-1:0]  data_q  [ENTRIES];

  logic [IW-1:0]      random_q, random_d;
  logic [IW-1:0]      probe_index_q, probe_index_d;
  logic               probe_miss_q, probe_miss_d;

  logic [ENTRIES-1:0] match_c;
  logic [IW-1:0]      lowest_idx_c;
  logic               any_c;
  logic               multi_c;

  logic               wr_en_c;
  logic               wr_rand_c;
  logic [IW-1:0]      wr_idx_c;

  // Per-entry tag/ASID compare; global entries ignore the ASID.
  always_comb begin
    match_c = '0;
    for (int unsigned i = 0; i < ENTRIES; i++) begin
      match_c[i] = flags_q[i].valid && (tag_q[i] == bus.vpn) &&
                   (flags_q[i].glb || (asid_q[i] == bus.asid));
    end
  end

  tlb_match_enc #(
    .N (ENTRIES)
  ) u_match_enc (
    .match_i      (match_c),
    .lowest_idx_o (lowest_idx_c),
    .any_o        (any_c),
    .multi_o      (multi_c)
  );

  // Flush beats both writes; indexed write beats random write.
  always_comb begin
    wr_en_c   = !bus.tlbinv && (bus.tlbwi || bus.tlbwr);
    wr_rand_c = !bus.tlbinv && !bus.tlbwi && bus.tlbwr;
    wr_idx_c  = bus.tlbwi ? bus.index : random_q;
  end

  always_comb begin
    random_d      = random_q;
    probe_index_d = probe_index_q;
    probe_miss_d  = probe_miss_q;
    if (wr_rand_c) random_d = random_q + IW'(1);
    if (bus.tlbp) begin
      probe_index_d = lowest_idx_c;
      probe_miss_d  = !any_c;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int unsigned i = 0; i < ENTRIES; i++) flags_q[i] <= '0;
    end else if (bus.tlbinv) begin
      for (int unsigned i = 0; i < ENTRIES; i++) flags_q[i].valid <= 1'b0;
    end else if (wr_en_c) begin
      flags_q[wr_idx_c] <= '{valid: 1'b1, glb: bus.pte_in[PTE_W-1]};
    end
  end

  // Payload needs no reset: it is only observed through a valid match.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      tag_q[wr_idx_c]  <= bus.vpn;
      asid_q[wr_idx_c] <= bus.asid;
      data_q[wr_idx_c] <= bus.pte_in;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      random_q      <= '0;
      probe_index_q <= '0;
      probe_miss_q  <= 1'b1;
    end else begin
      random_q      <= random_d;
      probe_index_q <= probe_index_d;
      probe_miss_q  <= probe_miss_d;
    end
  end

  assign bus.pte_out     = any_c ? data_q[lowest_idx_c] : '0;
  assign bus.tlb_hit     = any_c;
  assign bus.multi_hit   = multi_c;
  assign bus.probe_index = probe_index_q;
  assign bus.probe_miss  = probe_miss_q;
  assign bus.random      = random_q;

endmodule

// File: tb/tb_tlb_n_entry.sv
// Directed and randomized checks of tlb_n_entry against an array-based reference model.
module tb_tlb_n_entry;

  localparam int N = 8;

  logic clk = 1'b0;
  logic clrn;
  always #5 clk = ~clk;

  tlb_n_entry_if #(.ENTRIES(8), .VPN_W(20), .PTE_W(24), .ASID_W(8)) bus ();

  tlb_n_entry #(.ENTRIES(8), .VPN_W(20), .PTE_W(24), .ASID_W(8)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  bit          m_valid [N];
  logic [19:0] m_vpn   [N];
  logic [7:0]  m_asid  [N];
  logic [23:0] m_pte   [N];
  int          m_rand;
  int          m_pidx;
  bit          m_pmiss;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic void m_lookup(input logic [19:0] v, input logic [7:0] a,
                                   output int first, output int cnt);
    first = 0;
    cnt   = 0;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_vpn[i] == v && (m_pte[i][23] || m_asid[i] == a)) begin
        if (cnt == 0) first = i;
        cnt++;
      end
    end
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    m_rand  = 0;
    m_pidx  = 0;
    m_pmiss = 1'b1;
  endtask

  task automatic model_write(input int i, input logic [19:0] v, input logic [7:0] a,
                             input logic [23:0] pte);
    m_valid[i] = 1'b1;
    m_vpn[i]   = v;
    m_asid[i]  = a;
    m_pte[i]   = pte;
  endtask

  task automatic check_outputs(input string tag);
    int f, c;
    m_lookup(bus.vpn, bus.asid, f, c);
    chk({tag, ":hit"},   32'(bus.tlb_hit),   32'(c > 0));
    chk({tag, ":multi"}, 32'(bus.multi_hit), 32'(c > 1));
    chk({tag, ":pte"},   32'(bus.pte_out),   (c > 0) ? 32'(m_pte[f]) : 32'd0);
    chk({tag, ":rand"},  32'(bus.random),    32'(m_rand));
    chk({tag, ":pmiss"}, 32'(bus.probe_miss), 32'(m_pmiss));
    if (!m_pmiss) chk({tag, ":pidx"}, 32'(bus.probe_index), 32'(m_pidx));
  endtask

  task automatic step(input bit wi, input bit wr, input bit p, input bit inv, input int idx,
                      input logic [19:0] v, input logic [7:0] a, input logic [23:0] pte,
                      input string tag);
    int f, c;
    @(negedge clk);
    bus.tlbwi  = wi;
    bus.tlbwr  = wr;
    bus.tlbp   = p;
    bus.tlbinv = inv;
    bus.index  = 3'(idx);
    bus.vpn    = v;
    bus.asid   = a;
    bus.pte_in = pte;
    @(posedge clk);
    #1;
    m_lookup(v, a, f, c);
    if (p) begin
      m_pmiss = (c == 0);
      if (c > 0) m_pidx = f;
    end
    if (inv) begin
      for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
    end else if (wi) begin
      model_write(idx, v, a, pte);
    end else if (wr) begin
      model_write(m_rand, v, a, pte);
      m_rand = (m_rand + 1) % N;
    end
    check_outputs(tag);
    bus.tlbwi  = 1'b0;
    bus.tlbwr  = 1'b0;
    bus.tlbp   = 1'b0;
    bus.tlbinv = 1'b0;
  endtask

  task automatic look(input logic [19:0] v, input logic [7:0] a, input string tag);
    @(negedge clk);
    bus.vpn  = v;
    bus.asid = a;
    #1;
    check_outputs(tag);
  endtask

  initial begin
    bus.tlbwi  = 1'b0;
    bus.tlbwr  = 1'b0;
    bus.tlbp   = 1'b0;
    bus.tlbinv = 1'b0;
    bus.index  = '0;
    bus.vpn    = '0;
    bus.asid   = '0;
    bus.pte_in = '0;
    clrn       = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    chk("reset_pmiss_const", 32'(bus.probe_miss), 32'd1);
    @(negedge clk);
    clrn = 1'b1;

    // Indexed fill, then lookup of the fourth entry.
    for (int i = 0; i < N; i++)
      step(1, 0, 0, 0, i, 20'h80000 + 20'(i), 8'd1, 24'hff0000 + 24'(i), "wi_fill");
    look(20'h80003, 8'd1, "r040");
    chk("r040_hit", 32'(bus.tlb_hit), 32'd1);
    chk("r040_pte", 32'(bus.pte_out), 32'h00ff0003);

    // Reset, then random-pointer fill wraps back to 0.
    @(negedge clk);
    clrn = 1'b0;
    #1;
    model_reset();
    check_outputs("rst2");
    @(negedge clk);
    clrn = 1'b1;
    for (int i = 0; i < N; i++)
      step(0, 1, 0, 0, 0, 20'h80008 + 20'(i), 8'd2, 24'h100000 + 24'(i), "wr_fill");
    chk("r041_rand_wrap", 32'(bus.random), 32'd0);
    for (int i = 0; i < N; i++) begin
      step(0, 0, 1, 0, 0, 20'h80008 + 20'(i), 8'd2, 24'h0, "r041_probe");
      chk("r041_pidx", 32'(bus.probe_index), 32'(i));
      chk("r041_pte", 32'(bus.pte_out), 32'h00100000 + 32'(i));
    end

    // Indexed and random write together.
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 0, 0, 20'h90000 + 20'(i), 8'd3, 24'h000100 + 24'(i), "wr_adv");
    step(1, 1, 0, 0, 5, 20'ha0005, 8'd3, 24'h000555, "r042");
    chk("r042_rand", 32'(bus.random), 32'd3);
    step(0, 0, 1, 0, 0, 20'ha0005, 8'd3, 24'h0, "r042_probe");
    chk("r042_pidx", 32'(bus.probe_index), 32'd5);

    // ASID-private vs global entry.
    step(1, 0, 0, 0, 0, 20'h90010, 8'd1, 24'h7f0010, "r043_w1");
    look(20'h90010, 8'd2, "r043_other");
    chk("r043_miss", 32'(bus.tlb_hit), 32'd0);
    look(20'h90010, 8'd1, "r043_own");
    step(1, 0, 0, 0, 0, 20'h90010, 8'd1, 24'h800010, "r043_w2");
    look(20'h90010, 8'd2, "r043_glb");
    chk("r043_glb_hit", 32'(bus.tlb_hit), 32'd1);
    chk("r043_glb_pte", 32'(bus.pte_out), 32'h00800010);

    // Duplicate tag in entries 2 and 6.
    step(0, 0, 0, 1, 0, 20'h0, 8'd0, 24'h0, "inv");
    step(1, 0, 0, 0, 2, 20'h80001, 8'd1, 24'h012222, "r044_w2");
    step(1, 0, 0, 0, 6, 20'h80001, 8'd1, 24'h016666, "r044_w6");
    look(20'h80001, 8'd1, "r044_look");
    chk("r044_multi", 32'(bus.multi_hit), 32'd1);
    chk("r044_pte", 32'(bus.pte_out), 32'h00012222);
    step(0, 0, 1, 0, 0, 20'h80001, 8'd1, 24'h0, "r044_probe");
    chk("r044_pidx", 32'(bus.probe_index), 32'd2);

    // Probe sees contents from before a same-cycle write.
    step(1, 0, 1, 0, 1, 20'h80001, 8'd1, 24'h011111, "probe_prewrite");
    chk("prewrite_pidx", 32'(bus.probe_index), 32'd2);
    chk("prewrite_pte", 32'(bus.pte_out), 32'h00011111);

    // Flush overrides a simultaneous indexed write.
    step(1, 0, 0, 1, 3, 20'h80001, 8'd1, 24'h033333, "r045_inv");
    chk("r045_hit", 32'(bus.tlb_hit), 32'd0);
    step(0, 0, 1, 0, 0, 20'h80001, 8'd1, 24'h0, "r045_probe");
    chk("r045_pmiss", 32'(bus.probe_miss), 32'd1);

    // Reset asserted mid-cycle discards the pending write.
    step(1, 0, 0, 0, 4, 20'hb0004, 8'd1, 24'h044444, "pre_rst_w");
    step(0, 1, 0, 0, 0, 20'hb0005, 8'd1, 24'h055555, "pre_rst_wr");
    @(negedge clk);
    bus.tlbwi  = 1'b1;
    bus.index  = 3'd3;
    bus.vpn    = 20'hb0003;
    bus.asid   = 8'd1;
    bus.pte_in = 24'h033333;
    #2;
    clrn = 1'b0;
    #1;
    model_reset();
    check_outputs("midrst_async");
    @(posedge clk);
    #1;
    check_outputs("midrst_edge");
    bus.tlbwi = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    look(20'hb0003, 8'd1, "midrst_w3");
    look(20'hb0004, 8'd1, "midrst_w4");
    step(0, 1, 0, 0, 0, 20'hb0006, 8'd1, 24'h066666, "post_rst_wr");
    chk("post_rst_rand", 32'(bus.random), 32'd1);

    // Randomized traffic over a small tag/ASID pool to provoke duplicates.
    for (int n = 0; n < 300; n++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0, int'($urandom_range(0, 7)),
           20'h80000 + 20'($urandom_range(0, 5)), 8'($urandom_range(0, 3)),
           {1'($urandom_range(0, 1)), 23'($urandom)}, "rnd");
      if ($urandom_range(0, 3) == 0)
        look(20'h80000 + 20'($urandom_range(0, 5)), 8'($urandom_range(0, 3)), "rnd_look");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
